// File: rtl/sm4_core_round.sv
// sm4_core_round -- iterative SM4 block cipher datapath, one round per clock.
//
// Takes the 32 expanded round keys from the key-expansion block and encrypts
// or decrypts one 128-bit block in 32 cycles. The result is handed to the CTR
// keystream logic.
//
// Ports:
//   clk_sys, sys_rst       clock, synchronous active-high reset
//   key2core_rkey[1023:0]  round keys, rk[i] = key2core_rkey[32*i+31:32*i]
//   key2core_rkey_vld      round keys valid (level)
//   core_mode_dec          0 = encrypt, 1 = decrypt, sampled at accept
//   core_din[127:0]        input block, X0 = [127:96] .. X3 = [31:0]
//   core_din_vld/_rdy      input handshake
//   core_dout[127:0]       result block
//   core_dout_vld/_rdy     output handshake
//   core_abort             one-cycle pulse: block dropped on round-key loss
//
// Handshake: a transfer happens on a clk_sys edge where valid and ready are
// both high. The source keeps data and valid stable until that edge; ready may
// depend combinationally on state but never on the partner's valid.
//
// Optional feature, macro SM4_CORE_KEY_LATCH_EN: the round keys are copied
// into a local register at accept, key validity is only checked at accept and
// core_abort is tied low.

module sm4_core_round #(
  parameter int ROUNDS = 32
) (
  input  logic          clk_sys,
  input  logic          sys_rst,
  input  logic [1023:0] key2core_rkey,
  input  logic          key2core_rkey_vld,
  input  logic          core_mode_dec,
  input  logic [127:0]  core_din,
  input  logic          core_din_vld,
  output logic          core_din_rdy,
  output logic [127:0]  core_dout,
  output logic          core_dout_vld,
  input  logic          core_dout_rdy,
  output logic          core_abort
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  // SM4 S-box, entry i at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[2047 - 8 * int'(a) -: 8];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Round transform T = L(tau(x)).
  function automatic logic [31:0] t_fn(input logic [31:0] x);
    logic [31:0] b;
    b = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state;
  logic [4:0]  round_cnt;
  logic [31:0] x0, x1, x2, x3;
  logic        mode_q;
  logic        accept;
  logic [4:0]  rk_idx;
  logic [31:0] rk;
  logic [31:0] new_word;
  logic [1023:0] keys;

`ifdef SM4_CORE_KEY_LATCH_EN
  logic [1023:0] rkey_q;

  // Private copy so the upstream key block may change keys mid-operation.
  always_ff @(posedge clk_sys) begin
    if (accept) rkey_q <= key2core_rkey;
  end

  assign keys       = rkey_q;
  assign core_abort = 1'b0;
`else
  logic abort_q;

  assign keys       = key2core_rkey;
  assign core_abort = abort_q;
`endif

  assign core_din_rdy = (state == IDLE) & key2core_rkey_vld;
  assign accept       = core_din_vld & core_din_rdy;

  // Decryption is the same datapath with the key schedule reversed.
  assign rk_idx   = mode_q ? 5'(LAST - round_cnt) : round_cnt;
  assign rk       = keys[32 * rk_idx +: 32];
  assign new_word = x0 ^ t_fn(x1 ^ x2 ^ x3 ^ rk);

  always_ff @(posedge clk_sys) begin
    if (sys_rst) begin
      state         <= IDLE;
      round_cnt     <= '0;
      x0            <= '0;
      x1            <= '0;
      x2            <= '0;
      x3            <= '0;
      mode_q        <= 1'b0;
      core_dout     <= '0;
      core_dout_vld <= 1'b0;
`ifndef SM4_CORE_KEY_LATCH_EN
      abort_q       <= 1'b0;
`endif
    end else begin
`ifndef SM4_CORE_KEY_LATCH_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            x0        <= core_din[127:96];
            x1        <= core_din[95:64];
            x2        <= core_din[63:32];
            x3        <= core_din[31:0];
            mode_q    <= core_mode_dec;
            round_cnt <= '0;
            state     <= ROUND;
          end
        end
        ROUND: begin
`ifndef SM4_CORE_KEY_LATCH_EN
          if (!key2core_rkey_vld) begin
            // Keys went away mid-block: drop it, the result would be garbage.
            state     <= IDLE;
            round_cnt <= '0;
            abort_q   <= 1'b1;
          end else
`endif
          begin
            x0        <= x1;
            x1        <= x2;
            x2        <= x3;
            x3        <= new_word;
            round_cnt <= round_cnt + 5'd1;
            if (round_cnt == LAST) begin
              // Reverse transform R on the final four words.
              core_dout     <= {new_word, x3, x2, x1};
              core_dout_vld <= 1'b1;
              round_cnt     <= '0;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (core_dout_rdy) begin
            core_dout_vld <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_core_round.sv
// tb_sm4_core_round -- self-checking bench for sm4_core_round.
// Builds round keys with its own SM4 key schedule, computes expected blocks
// with a reference cipher model anchored on the published test vector, and
// matches DUT results through an expected-value queue.

module tb_sm4_core_round;

  logic          clk_sys = 1'b0;
  logic          sys_rst;
  logic [1023:0] key2core_rkey;
  logic          key2core_rkey_vld;
  logic          core_mode_dec;
  logic [127:0]  core_din;
  logic          core_din_vld;
  logic          core_din_rdy;
  logic [127:0]  core_dout;
  logic          core_dout_vld;
  logic          core_dout_rdy;
  logic          core_abort;

  sm4_core_round dut (
    .clk_sys(clk_sys), .sys_rst(sys_rst),
    .key2core_rkey(key2core_rkey), .key2core_rkey_vld(key2core_rkey_vld),
    .core_mode_dec(core_mode_dec), .core_din(core_din),
    .core_din_vld(core_din_vld), .core_din_rdy(core_din_rdy),
    .core_dout(core_dout), .core_dout_vld(core_dout_vld),
    .core_dout_rdy(core_dout_rdy), .core_abort(core_abort)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  localparam logic [127:0] MK = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [2047:0] SBOX_REF = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [31:0] m_rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] m_tau(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++)
      b[8*j +: 8] = SBOX_REF[2047 - 8 * int'(x[8*j +: 8]) -: 8];
    return b;
  endfunction

  function automatic logic [1023:0] m_expand(input logic [127:0] mk);
    logic [31:0] k [0:35];
    logic [31:0] ck, b;
    logic [1023:0] r;
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64]  ^ 32'h56aa3350;
    k[2] = mk[63:32]  ^ 32'h677d9197;
    k[3] = mk[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      b = m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ m_rotl(b, 13) ^ m_rotl(b, 23);
      r[32*i +: 32] = k[i+4];
    end
    return r;
  endfunction

  function automatic logic [127:0] m_cipher(input logic [127:0] din, input bit dec,
                                            input logic [1023:0] rks);
    logic [31:0] a, b, c, d, r, t, n;
    {a, b, c, d} = din;
    for (int i = 0; i < 32; i++) begin
      r = dec ? rks[32*(31-i) +: 32] : rks[32*i +: 32];
      t = m_tau(b ^ c ^ d ^ r);
      n = a ^ t ^ m_rotl(t, 2) ^ m_rotl(t, 10) ^ m_rotl(t, 18) ^ m_rotl(t, 24);
      {a, b, c, d} = {b, c, d, n};
    end
    return {d, c, b, a};
  endfunction

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  logic [127:0] pend_exp;
  int nchk = 0, nerr = 0;
  int acc_n = 0, out_n = 0, rise_n = 0, abort_n = 0;
  int acc_edge = 0, rise_edge = 0, hs_edge = 0;
  bit vld_seen = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sampled at the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk_sys) begin
    if (sys_rst) begin
      vld_seen = 1'b0;
    end else begin
      if (core_din_vld && core_din_rdy) begin
        exp_q.push_back(pend_exp);
        acc_edge = cyc + 1;
        acc_n++;
      end
      if (core_dout_vld && !vld_seen) begin
        rise_edge = cyc;
        rise_n++;
        check("latency", 128'(rise_edge - acc_edge), 128'd32);
      end
      vld_seen = core_dout_vld;
      if (core_dout_vld && core_dout_rdy) begin
        hs_edge = cyc + 1;
        out_n++;
        if (exp_q.size() == 0) check("unexpected_output", core_dout, 128'h0);
        else check("dout", core_dout, exp_q.pop_front());
      end
      if (core_abort) begin
        abort_n++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_block(input logic [127:0] din, input bit dec, input logic [127:0] exp);
    int start, n;
    start = acc_n;
    n = 0;
    core_din      = din;
    core_mode_dec = dec;
    pend_exp      = exp;
    core_din_vld  = 1'b1;
    while (acc_n == start && n < 300) begin
      tick();
      n++;
    end
    if (acc_n == start) check("accept_timeout", 128'(acc_n), 128'(start + 1));
    core_din_vld  = 1'b0;
    core_mode_dec = ~dec;  // must be ignored after accept
    core_din      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_n < target && n < 300) begin
      tick();
      n++;
    end
    if (out_n < target) check("output_timeout", 128'(out_n), 128'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dout"}, core_dout, 128'h0);
    check({tag, "_dout_vld"}, 128'(core_dout_vld), 128'd0);
    check({tag, "_abort"}, 128'(core_abort), 128'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] key;
    bit           dec;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  // ---------------- main sequence ----------------
  initial begin
    int o, a0, r0;
    logic [1023:0] rk_std;

    sys_rst = 1'b1;
    key2core_rkey = '0;
    key2core_rkey_vld = 1'b0;
    core_mode_dec = 1'b0;
    core_din = '0;
    core_din_vld = 1'b0;
    core_dout_rdy = 1'b1;
    pend_exp = '0;
    rk_std = m_expand(MK);

    vecs[0] = '{MK, 1'b0, MK, CT};
    vecs[1] = '{MK, 1'b1, CT, MK};
    for (int i = 2; i < 6; i++) begin
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].dec = bit'(i % 2);
      vecs[i].din = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].exp = m_cipher(vecs[i].din, vecs[i].dec, m_expand(vecs[i].key));
    end

    // Reset state.
    repeat (3) tick();
    check_idle_outputs("reset");
    sys_rst = 1'b0;
    tick();
    check_idle_outputs("after_reset");
    check("rdy_no_keys", 128'(core_din_rdy), 128'd0);

    // Input stalls while keys are invalid; the block is not lost.
    key2core_rkey = rk_std;
    core_din = MK;
    core_mode_dec = 1'b0;
    pend_exp = CT;
    core_din_vld = 1'b1;
    repeat (5) tick();
    check("stall_rdy", 128'(core_din_rdy), 128'd0);
    check("stall_no_accept", 128'(acc_n), 128'd0);
    key2core_rkey_vld = 1'b1;
    send_block(MK, 1'b0, CT);
    wait_out(1);

    // Table of vectors.
    for (int i = 0; i < 6; i++) begin
      key2core_rkey = m_expand(vecs[i].key);
      tick();
      o = out_n;
      send_block(vecs[i].din, vecs[i].dec, vecs[i].exp);
      wait_out(o + 1);
    end
    key2core_rkey = rk_std;
    tick();

    // Backpressure: result held, no accept until the output handshake.
    core_dout_rdy = 1'b0;
    o = out_n;
    send_block(MK, 1'b0, CT);
    for (int n = 0; n < 100 && !core_dout_vld; n++) tick();
    check("bp_vld", 128'(core_dout_vld), 128'd1);
    core_din = CT;
    core_mode_dec = 1'b1;
    pend_exp = MK;
    core_din_vld = 1'b1;
    for (int n = 0; n < 10; n++) begin
      check("bp_hold_dout", core_dout, CT);
      check("bp_rdy_low", 128'(core_din_rdy), 128'd0);
      tick();
    end
    core_dout_rdy = 1'b1;
    send_block(CT, 1'b1, MK);
    check("bp_next_accept", 128'(acc_edge), 128'(hs_edge + 1));
    wait_out(o + 2);

    // Key loss at round 15 with the key bus also corrupted.
    o = out_n;
    a0 = abort_n;
    r0 = rise_n;
    send_block(MK, 1'b0, CT);
    repeat (15) tick();
    key2core_rkey_vld = 1'b0;
    key2core_rkey = ~rk_std;
`ifdef SM4_CORE_KEY_LATCH_EN
    wait_out(o + 1);
`else
    repeat (40) tick();
    check("abort_pulses", 128'(abort_n - a0), 128'd1);
    check("abort_no_vld", 128'(rise_n - r0), 128'd0);
    check("abort_no_out", 128'(out_n), 128'(o));
    check("abort_queue", 128'(exp_q.size()), 128'd0);
`endif
    key2core_rkey = rk_std;
    key2core_rkey_vld = 1'b1;
    tick();
    check("idle_after_keyloss", 128'(core_din_rdy), 128'd1);

    // Reset mid-round (round 20).
    send_block(MK, 1'b0, CT);
    repeat (19) tick();
    sys_rst = 1'b1;
    tick();
    check_idle_outputs("midreset");
    check("midreset_idle", 128'(core_din_rdy), 128'd1);
    sys_rst = 1'b0;
    exp_q.delete();
    o = out_n;
    send_block(MK, 1'b0, CT);
    wait_out(o + 1);

    // Back-to-back with the sink always ready.
    tick();
    o = out_n;
    send_block(MK, 1'b0, CT);
    send_block(CT, 1'b1, MK);
    check("b2b_gap", 128'(acc_edge - rise_edge), 128'd2);
    wait_out(o + 2);

    repeat (3) tick();
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    check("final_abort_low", 128'(core_abort), 128'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
